// File: rtl/mc_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mc_cpu_pkg
// Shared definitions for the multi-cycle CPU core: FSM state type, ALU op
// codes, writeback-select codes, instruction field positions and register
// file geometry. Imported by mc_cpu_regfile and mc_cpu_core.
// -----------------------------------------------------------------------------
package mc_cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;
   localparam logic [3:0] ALU_EQ  = 4'b1000;
   localparam logic [3:0] ALU_NE  = 4'b1001;
   localparam logic [3:0] ALU_LT  = 4'b1010;
   localparam logic [3:0] ALU_GE  = 4'b1011;
   localparam logic [3:0] ALU_LTU = 4'b1100;
   localparam logic [3:0] ALU_GEU = 4'b1101;

   // Writeback select codes; WS_HALT doubles as the halt instruction
   localparam logic [1:0] WS_CONST = 2'b00;
   localparam logic [1:0] WS_SW    = 2'b01;
   localparam logic [1:0] WS_ALU   = 2'b10;
   localparam logic [1:0] WS_HALT  = 2'b11;

   // Instruction field positions
   localparam int F_JUMP     = 31;
   localparam int F_BRANCH   = 30;
   localparam int F_WE       = 29;
   localparam int F_WS_HI    = 28;
   localparam int F_WS_LO    = 27;
   localparam int F_OP_HI    = 26;
   localparam int F_OP_LO    = 23;
   localparam int F_A1_HI    = 22;
   localparam int F_A1_LO    = 18;
   localparam int F_A2_HI    = 17;
   localparam int F_A2_LO    = 13;
   localparam int F_A3_HI    = 12;
   localparam int F_A3_LO    = 8;
   localparam int F_CONST_HI = 7;
   localparam int F_CONST_LO = 0;

   // Register file geometry
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

endpackage

// File: rtl/mc_cpu_regfile.sv
// -----------------------------------------------------------------------------
// mc_cpu_regfile
// 32 x XLEN register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-high reset clearing every entry. Register x0 is
// never written and always reads as zero.
//
// Ports:
//   clk            clock, writes on rising edge
//   rst            asynchronous active-high reset
//   we             write enable
//   waddr, wdata   write address / data
//   raddr1/2       read addresses
//   rdata1/2       combinational read data (old value on same-cycle write)
// -----------------------------------------------------------------------------
module mc_cpu_regfile
   import mc_cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [XLEN-1:0]   rdata1,
   output logic [XLEN-1:0]   rdata2
);

   logic [XLEN-1:0] regs [NUM_REGS];

   // NOTE: every entry is cleared by reset, so this array builds from flops
   // rather than a RAM macro; the CPU relies on all registers reading zero
   // after reset.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mc_cpu_core.sv
// -----------------------------------------------------------------------------
// mc_cpu_core
// Multi-cycle CPU: IDLE -> FETCH -> EXEC -> FETCH ... with a HALT sink state.
// One instruction takes at least two cycles (FETCH waits for imem_ack_i, EXEC
// is a single cycle whose closing edge performs writeback and PC update).
//
// Parameters: XLEN (datapath width, 8..64), PC_W (fetch address width),
//             RESET_PC (PC after reset).
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   imem_req_o     registered fetch request (high throughout FETCH)
//   imem_addr_o    fetch address (= PC)
//   imem_ack_i     fetch accept, only honoured while imem_req_o is high
//   imem_rdata_i   instruction word
//   sw_i           switch input, written to the register file by WS=01
//   hex_o          registered copy of register x1
//   halted_o       high while in HALT
//
// Build option: define MC_CPU_SW_SYNC_EN to route sw_i through a two-flop
// synchroniser before the writeback mux; otherwise sw_i is used directly.
// -----------------------------------------------------------------------------
module mc_cpu_core
   import mc_cpu_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter int          PC_W     = 10,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic [XLEN-1:0] sw_i,
   output logic [XLEN-1:0] hex_o,
   output logic            halted_o
);

   localparam int SHW = $clog2(XLEN);

   state_t          state, next_state;
   logic [PC_W-1:0] pc, pc_next, pc_off;
   logic [31:0]     ir;
   logic            req;
   logic [XLEN-1:0] hex;

   // Decoded instruction fields
   logic              f_jump, f_branch, f_we;
   logic [1:0]        f_ws;
   logic [3:0]        f_op;
   logic [REG_AW-1:0] f_a1, f_a2, f_a3;
   logic [7:0]        f_const;

   logic [XLEN-1:0] rd1, rd2, alu_res, wb_data, imm_sext, sw_val;
   logic            alu_flag, wr_en;
   logic [SHW-1:0]  shamt;

   assign f_jump   = ir[F_JUMP];
   assign f_branch = ir[F_BRANCH];
   assign f_we     = ir[F_WE];
   assign f_ws     = ir[F_WS_HI:F_WS_LO];
   assign f_op     = ir[F_OP_HI:F_OP_LO];
   assign f_a1     = ir[F_A1_HI:F_A1_LO];
   assign f_a2     = ir[F_A2_HI:F_A2_LO];
   assign f_a3     = ir[F_A3_HI:F_A3_LO];
   assign f_const  = ir[F_CONST_HI:F_CONST_LO];

   assign imm_sext = XLEN'($signed(f_const));
   assign pc_off   = PC_W'($signed(f_const));

   // Switch input path
`ifdef MC_CPU_SW_SYNC_EN
   logic [XLEN-1:0] sw_meta, sw_sync;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_i;
         sw_sync <= sw_meta;
      end
   end

   assign sw_val = sw_sync;
`else
   assign sw_val = sw_i;
`endif

   // Register file; the halt instruction never writes even with WE set
   assign wr_en = (state == ST_EXEC) && f_we && (f_ws != WS_HALT) && (f_a3 != '0);

   mc_cpu_regfile #(
      .XLEN (XLEN)
   ) u_regfile (
      .clk    (clk_i),
      .rst    (rst_i),
      .we     (wr_en),
      .waddr  (f_a3),
      .wdata  (wb_data),
      .raddr1 (f_a1),
      .raddr2 (f_a2),
      .rdata1 (rd1),
      .rdata2 (rd2)
   );

   // ALU: comparisons drive the branch flag and return it zero-extended
   assign shamt = rd2[SHW-1:0];

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      alu_res  = '0;
      alu_flag = 1'b0;
      case (f_op)
         ALU_ADD: alu_res = rd1 + rd2;
         ALU_SUB: alu_res = rd1 - rd2;
         ALU_AND: alu_res = rd1 & rd2;
         ALU_OR:  alu_res = rd1 | rd2;
         ALU_XOR: alu_res = rd1 ^ rd2;
         ALU_SLL: alu_res = rd1 << shamt;
         ALU_SRL: alu_res = rd1 >> shamt;
         ALU_SRA: alu_res = $signed(rd1) >>> shamt;
         ALU_EQ: begin
            alu_flag = (rd1 == rd2);
            alu_res  = XLEN'(alu_flag);
         end
         ALU_NE: begin
            alu_flag = (rd1 != rd2);
            alu_res  = XLEN'(alu_flag);
         end
         ALU_LT: begin
            alu_flag = ($signed(rd1) < $signed(rd2));
            alu_res  = XLEN'(alu_flag);
         end
         ALU_GE: begin
            alu_flag = ($signed(rd1) >= $signed(rd2));
            alu_res  = XLEN'(alu_flag);
         end
         ALU_LTU: begin
            alu_flag = (rd1 < rd2);
            alu_res  = XLEN'(alu_flag);
         end
         ALU_GEU: begin
            alu_flag = (rd1 >= rd2);
            alu_res  = XLEN'(alu_flag);
         end
         default: begin
            alu_res  = '0;
            alu_flag = 1'b0;
         end
      endcase
   end

   // Writeback data select
   always_comb begin
      wb_data = '0;
      case (f_ws)
         WS_CONST: wb_data = imm_sext;
         WS_SW:    wb_data = sw_val;
         WS_ALU:   wb_data = alu_res;
         default:  wb_data = '0;
      endcase
   end

   // Next PC: jump has priority over a taken branch
   always_comb begin
      pc_next = pc + PC_W'(1);
      if (f_jump) begin
         pc_next = pc + pc_off;
      end else if (f_branch && alu_flag) begin
         pc_next = pc + pc_off;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  next_state = ST_FETCH;
         ST_FETCH: if (imem_ack_i) next_state = ST_EXEC;
         ST_EXEC:  next_state = (f_ws == WS_HALT) ? ST_HALT : ST_FETCH;
         ST_HALT:  next_state = ST_HALT;
         default:  next_state = ST_IDLE;
      endcase
   end

   // State, PC, IR, request and x1 mirror
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
         pc    <= PC_W'(RESET_PC);
         ir    <= '0;
         req   <= 1'b0;
         hex   <= '0;
      end else begin
         state <= next_state;
         // Registered request follows the state being entered, so it is high
         // exactly while the FSM sits in FETCH.
         req   <= (next_state == ST_FETCH);
         if ((state == ST_FETCH) && imem_ack_i) begin
            ir <= imem_rdata_i;
         end
         if ((state == ST_EXEC) && (f_ws != WS_HALT)) begin
            pc <= pc_next;
         end
         if (wr_en && (f_a3 == REG_AW'(1))) begin
            hex <= wb_data;
         end
      end
   end

   assign imem_req_o  = req;
   assign imem_addr_o = pc;
   assign hex_o       = hex;
   assign halted_o    = (state == ST_HALT);

endmodule

// File: tb/tb_mc_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_mc_cpu_core
// Directed bench for mc_cpu_core (XLEN=32, PC_W=10, RESET_PC=0). An
// instruction memory array answers fetches; expected fetch addresses and x1
// values are queued when each step is issued and compared when the core
// fetches / completes the instruction.
// -----------------------------------------------------------------------------
module tb_mc_cpu_core;

   localparam int XLEN = 32;
   localparam int PC_W = 10;

   logic            clk = 1'b0;
   logic            rst;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic [XLEN-1:0] sw;
   logic [XLEN-1:0] hex;
   logic            halted;

   logic [31:0] imem [1024];
   assign imem_rdata = imem[imem_addr];

   always #5 clk = ~clk;

   mc_cpu_core #(
      .XLEN     (XLEN),
      .PC_W     (PC_W),
      .RESET_PC (0)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_ack_i   (imem_ack),
      .imem_rdata_i (imem_rdata),
      .sw_i         (sw),
      .hex_o        (hex),
      .halted_o     (halted)
   );

   int checks = 0;
   int errors = 0;

   logic [PC_W-1:0] addr_q [$];
   logic [31:0]     hex_q  [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic j, input logic b, input logic we,
                                      input logic [1:0] ws, input logic [3:0] op,
                                      input logic [4:0] a1, input logic [4:0] a2,
                                      input logic [4:0] a3, input logic [7:0] k);
      return {j, b, we, ws, op, a1, a2, a3, k};
   endfunction

   function automatic logic [31:0] li(input logic [4:0] a3, input logic [7:0] k);
      return mk(1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 5'd0, 5'd0, a3, k);
   endfunction

   function automatic logic [31:0] alu(input logic [3:0] op, input logic [4:0] a1,
                                       input logic [4:0] a2, input logic [4:0] a3);
      return mk(1'b0, 1'b0, 1'b1, 2'b10, op, a1, a2, a3, 8'h00);
   endfunction

   function automatic logic [31:0] jmp(input logic [7:0] k);
      return mk(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0, k);
   endfunction

   function automatic logic [31:0] br(input logic [3:0] op, input logic [4:0] a1,
                                      input logic [4:0] a2, input logic [7:0] k);
      return mk(1'b0, 1'b1, 1'b0, 2'b10, op, a1, a2, 5'd0, k);
   endfunction

   // Wait (bounded) for a fetch request, compare its address with the queue
   // head, let the accepting edge pass and confirm the request drops in EXEC.
   task automatic do_fetch(input string tag);
      int n;
      logic [PC_W-1:0] exp_a;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_req"}, imem_req, 1'b1);
      exp_a = addr_q.pop_front();
      check({tag, "_addr"}, imem_addr, exp_a);
      @(negedge clk);
      check({tag, "_exec_req"}, imem_req, 1'b0);
   endtask

   // One full instruction: fetch at address a, then x1 mirror must equal h.
   task automatic step(input string tag, input logic [PC_W-1:0] a, input logic [31:0] h);
      addr_q.push_back(a);
      hex_q.push_back(h);
      do_fetch(tag);
      @(negedge clk);
      check({tag, "_hex"}, hex, hex_q.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst      = 1'b1;
      imem_ack = 1'b1;
      sw       = 32'h1234_5678;
      for (int i = 0; i < 1024; i++) imem[i] = '0;

      // Program 1: loads, x1 doubling, branches and PC wrap
      imem[0]  = li(5'd1, 8'hFF);
      imem[1]  = alu(4'b0000, 5'd1, 5'd1, 5'd1);
      imem[2]  = li(5'd2, 8'd5);
      imem[3]  = li(5'd3, 8'd5);
      imem[4]  = jmp(8'd6);
      imem[10] = br(4'b1000, 5'd2, 5'd3, 8'hFC);
      imem[6]  = jmp(8'd4);
      imem[11] = jmp(8'hF4);
      imem[1023] = jmp(8'h02);

      repeat (2) @(negedge clk);
      check("rst_req", imem_req, 1'b0);
      check("rst_hex", hex, 32'h0);
      check("rst_halted", halted, 1'b0);
      check("rst_addr", imem_addr, 10'd0);

      rst = 1'b0;
      check("rel_req_low", imem_req, 1'b0);
      @(negedge clk);
      check("rel_req_high", imem_req, 1'b1);
      check("rel_addr", imem_addr, 10'd0);

      step("ld_x1",  10'd0, 32'hFFFF_FFFF);
      step("add_x1", 10'd1, 32'hFFFF_FFFE);
      step("ld_x2",  10'd2, 32'hFFFF_FFFE);
      step("ld_x3",  10'd3, 32'hFFFF_FFFE);
      step("jmp4",   10'd4, 32'hFFFF_FFFE);
      step("beq",    10'd10, 32'hFFFF_FFFE);
      imem[10] = br(4'b1001, 5'd2, 5'd3, 8'hFC);
      step("jmp6",   10'd6, 32'hFFFF_FFFE);
      step("bne",    10'd10, 32'hFFFF_FFFE);
      step("jmp11",  10'd11, 32'hFFFF_FFFE);

      // Program 2 overlays low memory; only 1023 remains to run from program 1
      imem[1]  = li(5'd0, 8'd7);
      imem[2]  = alu(4'b0000, 5'd0, 5'd0, 5'd1);
      imem[3]  = mk(1'b0, 1'b0, 1'b1, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd1, 8'h00);
      imem[4]  = li(5'd4, 8'h81);
      imem[5]  = alu(4'b0111, 5'd4, 5'd2, 5'd1);
      imem[6]  = alu(4'b0110, 5'd4, 5'd2, 5'd1);
      imem[7]  = alu(4'b1010, 5'd4, 5'd2, 5'd1);
      imem[8]  = alu(4'b1100, 5'd4, 5'd2, 5'd1);
      imem[9]  = alu(4'b0001, 5'd2, 5'd4, 5'd1);
      imem[10] = alu(4'b0101, 5'd2, 5'd3, 5'd1);
      imem[11] = alu(4'b1110, 5'd2, 5'd3, 5'd1);
      imem[12] = alu(4'b0100, 5'd4, 5'd2, 5'd1);
      imem[13] = mk(1'b0, 1'b0, 1'b1, 2'b11, 4'b0000, 5'd0, 5'd0, 5'd1, 8'h55);

      step("jwrap", 10'd1023, 32'hFFFF_FFFE);
      step("wr_x0", 10'd1, 32'hFFFF_FFFE);
      step("add_x0", 10'd2, 32'h0000_0000);

      // Fetch stall: address, request and state must hold
      imem_ack = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_req", imem_req, 1'b1);
         check("stall_addr", imem_addr, 10'd3);
         check("stall_hex", hex, 32'h0);
      end
      imem_ack = 1'b1;

      step("sw_x1",  10'd3, 32'h1234_5678);
      step("ld_x4",  10'd4, 32'h1234_5678);
      step("sra",    10'd5, 32'hFFFF_FFFC);
      step("srl",    10'd6, 32'h07FF_FFFC);
      step("lt",     10'd7, 32'h0000_0001);
      step("ltu",    10'd8, 32'h0000_0000);
      step("sub",    10'd9, 32'h0000_0084);
      step("sll",    10'd10, 32'h0000_00A0);
      step("bad_op", 10'd11, 32'h0000_0000);
      step("xor",    10'd12, 32'hFFFF_FF84);
      step("halt",   10'd13, 32'hFFFF_FF84);
      check("halt_flag", halted, 1'b1);
      repeat (6) begin
         @(negedge clk);
         check("halt_req", imem_req, 1'b0);
      end
      check("halt_hold", halted, 1'b1);
      check("halt_hex", hex, 32'hFFFF_FF84);

      // Reset leaves HALT
      rst = 1'b1;
      #1;
      check("rst2_halted", halted, 1'b0);
      check("rst2_hex", hex, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      imem[0] = li(5'd1, 8'h11);
      imem[1] = li(5'd1, 8'h22);
      imem[2] = mk(1'b0, 1'b0, 1'b1, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd1, 8'h00);

      @(negedge clk);
      step("p3_a", 10'd0, 32'h0000_0011);

      // Reset in the middle of FETCH
      rst = 1'b1;
      #1;
      check("rst_fetch_req", imem_req, 1'b0);
      check("rst_fetch_addr", imem_addr, 10'd0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_fetch_hex", hex, 32'h0);

      @(negedge clk);
      step("p3_b", 10'd0, 32'h0000_0011);

      // Reset in the middle of EXEC with a pending write to x1
      addr_q.push_back(10'd1);
      do_fetch("p3_pend");
      rst = 1'b1;
      #1;
      check("rst_exec_req", imem_req, 1'b0);
      @(negedge clk);
      check("rst_exec_hex", hex, 32'h0);
      rst = 1'b0;

      @(negedge clk);
      step("p3_c", 10'd0, 32'h0000_0011);
      step("p3_d", 10'd1, 32'h0000_0022);

      // Switch changes during FETCH; direct path samples it at EXEC close
      sw = 32'h0000_00A5;
      step("sw_late", 10'd2, 32'h0000_00A5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
